// File: rtl/cond_pkg.sv
// Shared encodings for the pipelined condition unit: predicate codes,
// cond/flag bit positions and the predicate selector.
package cond_pkg;

  localparam logic [2:0] PRED_NEVER  = 3'd0;
  localparam logic [2:0] PRED_EQ     = 3'd1;
  localparam logic [2:0] PRED_LT     = 3'd2;
  localparam logic [2:0] PRED_LE     = 3'd3;
  localparam logic [2:0] PRED_ALWAYS = 3'd4;
  localparam logic [2:0] PRED_NE     = 3'd5;
  localparam logic [2:0] PRED_GE     = 3'd6;
  localparam logic [2:0] PRED_GT     = 3'd7;

  localparam int COND_W   = 5;
  localparam int COND_SRC = 3;
  localparam int COND_UNS = 4;

  localparam int FLG_W = 4;
  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_C = 2;
  localparam int FLG_V = 3;

  function automatic logic pred_eval(input logic [2:0] pred,
                                     input logic       less,
                                     input logic       zero);
    logic res;
    case (pred)
      PRED_NEVER:  res = 1'b0;
      PRED_EQ:     res = zero;
      PRED_LT:     res = less;
      PRED_LE:     res = less | zero;
      PRED_ALWAYS: res = 1'b1;
      PRED_NE:     res = ~zero;
      PRED_GE:     res = ~less;
      PRED_GT:     res = ~less & ~zero;
      default:     res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cond_flag_eval.sv
// Combinational flag/predicate evaluation of A - B' where B' is B or zero.
module cond_flag_eval
  import cond_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [COND_W-1:0] cond,
  output logic [FLG_W-1:0]  flags,
  output logic              result
);

  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH:0]   diff_s;
  logic             less_s;

  // Subtract at WIDTH+1 bits so the top bit is the unsigned borrow; with
  // B' forced to zero both C and V fall out as zero naturally.
  always_comb begin
    b_eff_s = {WIDTH{1'b0}};
    if (cond[COND_SRC]) begin
      b_eff_s = b;
    end else begin
      b_eff_s = {WIDTH{1'b0}};
    end
    diff_s = {1'b0, a} - {1'b0, b_eff_s};
    flags          = {FLG_W{1'b0}};
    flags[FLG_Z]   = (diff_s[WIDTH-1:0] == {WIDTH{1'b0}});
    flags[FLG_N]   = diff_s[WIDTH-1];
    flags[FLG_C]   = diff_s[WIDTH];
    flags[FLG_V]   = (a[WIDTH-1] ^ b_eff_s[WIDTH-1]) & (a[WIDTH-1] ^ diff_s[WIDTH-1]);
    less_s         = cond[COND_UNS] ? flags[FLG_C] : (flags[FLG_N] ^ flags[FLG_V]);
    result         = pred_eval(cond[2:0], less_s, flags[FLG_Z]);
  end

endmodule

// File: rtl/cond_unit_pipe.sv
// Two-stage valid/ready condition pipeline: operand capture, then flag and
// predicate evaluation, with a saturating count of taken results.
module cond_unit_pipe
  import cond_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COND_W-1:0] cond,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              result,
  output logic [FLG_W-1:0]  flags,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);

  logic              s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [COND_W-1:0] cond_q, cond_d;
  logic              out_valid_q, out_valid_d;
  logic              result_q, result_d;
  logic [FLG_W-1:0]  flags_q, flags_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              accept_s, s2_load_s, hand_off_s;
  logic              eval_result_s;
  logic [FLG_W-1:0]  eval_flags_s;

  cond_flag_eval #(.WIDTH(WIDTH)) u_eval (
    .a      (a_q),
    .b      (b_q),
    .cond   (cond_q),
    .flags  (eval_flags_s),
    .result (eval_result_s)
  );

  // Handshake: stage 2 refills whenever its slot is empty or being taken.
  assign hand_off_s = out_valid_q & out_ready;
  assign s2_load_s  = s1_valid_q & (~out_valid_q | out_ready);
  assign in_ready   = rst & (~s1_valid_q | s2_load_s);
  assign accept_s   = in_valid & in_ready;

  // Next-state for both pipeline stages and the taken counter.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    cond_d      = cond_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    cnt_d       = cnt_q;

    if (accept_s) begin
      s1_valid_d = 1'b1;
      a_d        = a;
      b_d        = b;
      cond_d     = cond;
    end else if (s2_load_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end

    if (s2_load_s) begin
      out_valid_d = 1'b1;
      result_d    = eval_result_s;
      flags_d     = eval_flags_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    if (clr_cnt) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (hand_off_s && result_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q  <= 1'b0;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      cond_q      <= {COND_W{1'b0}};
      out_valid_q <= 1'b0;
      result_q    <= 1'b0;
      flags_q     <= {FLG_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
    end else begin
      s1_valid_q  <= s1_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cond_q      <= cond_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;
  assign taken_cnt = cnt_q;

endmodule

// File: doc/cond_unit_pipe.md
# cond_unit_pipe

Parametrised, pipelined successor to the 8-bit compare-to-zero condition block in the OVERTURE branch path. It evaluates a condition code against one operand (compare with zero) or two operands (A vs B), in signed or unsigned mode, and produces a registered result plus Z/N/C/V flags. A valid/ready handshake links it to the decode and branch stages. A saturating counter tracks taken results for profiling.

## Interface
- WIDTH, 8, operand width (≥2)
- CNT_W, 16, width of the taken-result counter
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- in_valid  in  1  operand/condition offered
- in_ready  out  1  block accepts this cycle
- cond  in  5  [2:0] predicate, [3] source (0: A vs 0, 1: A vs B), [4] 0 signed / 1 unsigned
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B (ignored when cond[3]=0)
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- result  out  1  condition outcome
- flags  out  4  {V,C,N,Z} of A−B (B=0 in zero mode)
- clr_cnt  in  1  synchronous clear of taken_cnt
- taken_cnt  out  CNT_W  number of handed-off results equal to 1, saturating

## Operation
- Predicate encoding (cond[2:0]): 0 never, 1 ==, 2 <, 3 <=, 4 always, 5 !=, 6 >=, 7 >.
- Stage 1 registers a, b and cond when in_valid && in_ready.
- Stage 2 computes diff = A − B' at WIDTH+1 bits, where B' = b if cond[3]=1, else 0. It registers result and flags.
- Z = diff[WIDTH-1:0]==0. N = diff[WIDTH-1]. C = borrow (A<B' unsigned). V = signed overflow of the subtraction. In zero mode C=0 and V=0.
- less = N^V when signed, C when unsigned. Unsigned "<0" is therefore always 0, and unsigned ">=0" is always 1.
- eq = Z, le = less|Z, ge = !less, gt = !less&!Z, ne = !Z.
- Handshake: a stage advances when its successor is empty or itself advancing. out_valid holds while !out_ready. result and flags stay stable while out_valid && !out_ready.
- in_ready = rst && (!s1_valid || s1 advancing). This is a combinational path from out_ready to in_ready, which is permitted.
- taken_cnt increments on out_valid && out_ready && result. It saturates at 2^CNT_W−1. If clr_cnt coincides with an increment, clr_cnt wins and the counter becomes 0.

## Timing
- Latency: 2 cycles from accept to out_valid.
- Throughput: one result per cycle with out_ready held high.
- Capacity: 2 entries (one per stage). With out_ready low, in_ready drops after 2 accepts.
- Reset (asynchronous, at any time including mid-flight): stage valids, out_valid, result, flags and taken_cnt go to 0 immediately, and in_ready is 0 while rst=0. In-flight entries are discarded. The first output after release comes from the first input accepted after release.
- Ordering: strictly FIFO, with no drop or duplication under any pattern of stalls.

## Structure
- Package cond_pkg holds:
  - predicate localparams (PRED_NEVER … PRED_GT)
  - cond bit indices (COND_SRC=3, COND_UNS=4)
  - flag indices (FLG_Z=0, FLG_N=1, FLG_C=2, FLG_V=3)
- One combinational sub-module, cond_flag_eval (WIDTH): takes A, B, cond and returns flags and result. It is instantiated in stage 2.
- cond_unit_pipe contains the two pipeline registers, the handshake logic and the counter.

## Test plan
- WIDTH=8, a=0x00, cond=5'b00001 → result=1, flags Z=1, out_valid exactly 2 cycles after accept.
- a=0x80, cond=5'b00010 (signed <0) → result=1, N=1. Repeat with cond=5'b10010 (unsigned) → result=0.
- a=0x7F, b=0x80, cond=5'b01010 (signed A<B) → result=0, flags {V,C,N,Z}=4'b1110. Repeat with cond=5'b11010 → result=1.
- Hold out_ready=0 and offer 3 transfers → exactly 2 accepted and in_ready=0. Release → 3 results in order, none lost.
- CNT_W=4, 17 taken results → taken_cnt=15. Assert clr_cnt in the same cycle as a taken hand-off → taken_cnt=0.
- Both stages full, pulse rst low mid-cycle → out_valid=0 and taken_cnt=0 immediately. After release, the first output matches the first post-reset input.
